// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, LSB first.
// A start in IDLE or DONE captures the operands; WIDTH cycles of RUN follow,
// then a single DONE cycle in which sum/cout are valid.
// Optional feature: define SERIAL_ADDER_OVF_EN to add a registered
// two's-complement overflow output (ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-adder slice for the bit currently selected by the counter
    logic ai, bi, s_bit, carry_n;
    always_comb begin
        ai      = a_q[cnt_q];
        bi      = b_q[cnt_q];
        s_bit   = ai ^ bi ^ carry_q;
        carry_n = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    end

    // Next-state and datapath updates; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            RUN: begin
                sum_d[cnt_q] = s_bit;
                carry_d      = carry_n;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = carry_n;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB at this point
                    ovf_d   = carry_q ^ carry_n;
`endif
                end
            end
            default: begin
                // IDLE and DONE behave alike: accept a new operation or rest
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Status decoded straight from the registered state
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule
